// File: rtl/clint_bridge_pkg.sv
// Shared types and constants for the CLINT AXI4 slave bridge.
// Address window helper is used only when CLINT_BRIDGE_ADDR_CHECK_EN is defined.
package clint_bridge_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned ID_W   = 10;

  typedef enum logic [2:0] {IDLE, WDATA, ACCESS, RRESP, BRESP} state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [15:0] WIN_MSIP     = 16'h0000;
  localparam logic [15:0] WIN_MTIMECMP = 16'h4000;
  localparam logic [15:0] WIN_MTIME    = 16'hBFF8;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
  } axi_ax_t;

  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] strb;
    logic                last;
  } axi_w_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } axi_b_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   r_valid;
    axi_r_t r;
  } axi_rsp_t;

  // Each 16 KiB window is identified by its top two address bits; mtime is a single word.
  function automatic logic addr_legal(input logic [15:0] a);
    return (a[2:0] == 3'b000) &&
           ((a[15:14] == WIN_MSIP[15:14]) || (a[15:14] == WIN_MTIMECMP[15:14]) ||
            (a == WIN_MTIME));
  endfunction

endpackage

// File: rtl/clint_axi_bridge.sv
// AXI4 single-beat slave to CLINT one-cycle register strobe bridge.
// Define CLINT_BRIDGE_ADDR_CHECK_EN to reject unaligned / out-of-window accesses with SLVERR.
module clint_axi_bridge
  import clint_bridge_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter type axi_req_slv_t = axi_req_t,
  parameter type axi_rsp_slv_t = axi_rsp_t
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  axi_req_slv_t              axi_req_i,
  output axi_rsp_slv_t              axi_resp_o,
  output logic [AXI_ADDR_WIDTH-1:0] address_o,
  output logic                      en_o,
  output logic                      we_o,
  output logic [7:0]                be_o,
  output logic [63:0]               data_o,
  input  logic [63:0]               data_i
);

  if (AXI_DATA_WIDTH != 64) begin : g_data_width_check
    $error("clint_axi_bridge: AXI_DATA_WIDTH must be 64");
  end

  state_e                    state_q;
  logic                      prio_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [7:0]                len_q;
  logic [7:0]                cnt_q;
  logic [63:0]               wdata_q;
  logic [63:0]               rdata_q;
  logic [7:0]                be_q;
  logic                      err_q;
  logic                      en_q;
  logic                      we_q;
  logic                      rvalid_q;
  logic                      bvalid_q;

  logic aw_ready, ar_ready, w_ready;
  logic aw_hs, ar_hs, w_hs, r_hs, b_hs;
  logic ar_legal, w_legal;

  // Priority bit only matters when both address channels are valid together.
  assign aw_ready = (state_q == IDLE) && !rst_i && (prio_q || !axi_req_i.ar_valid);
  assign ar_ready = (state_q == IDLE) && !rst_i && (!prio_q || !axi_req_i.aw_valid);
  assign w_ready  = (state_q == WDATA);

  assign aw_hs = axi_req_i.aw_valid && aw_ready;
  assign ar_hs = axi_req_i.ar_valid && ar_ready;
  assign w_hs  = axi_req_i.w_valid && w_ready;
  assign r_hs  = rvalid_q && axi_req_i.r_ready;
  assign b_hs  = bvalid_q && axi_req_i.b_ready;

`ifdef CLINT_BRIDGE_ADDR_CHECK_EN
  assign ar_legal = addr_legal(axi_req_i.ar.addr[15:0]);
  assign w_legal  = addr_legal(addr_q[15:0]);
`else
  assign ar_legal = 1'b1;
  assign w_legal  = 1'b1;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      prio_q   <= 1'b1;
      addr_q   <= '0;
      id_q     <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      be_q     <= '0;
      err_q    <= 1'b0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      rvalid_q <= 1'b0;
      bvalid_q <= 1'b0;
    end else begin
      en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (aw_hs) begin
            addr_q  <= axi_req_i.aw.addr;
            id_q    <= axi_req_i.aw.id;
            len_q   <= axi_req_i.aw.len;
            prio_q  <= !prio_q;
            state_q <= WDATA;
          end else if (ar_hs) begin
            addr_q  <= axi_req_i.ar.addr;
            id_q    <= axi_req_i.ar.id;
            len_q   <= axi_req_i.ar.len;
            cnt_q   <= axi_req_i.ar.len;
            prio_q  <= !prio_q;
            be_q    <= 8'hFF;
            we_q    <= 1'b0;
            rdata_q <= '0;
            if (axi_req_i.ar.len == 8'd0) begin
              en_q    <= ar_legal;
              err_q   <= !ar_legal;
              state_q <= ACCESS;
            end else begin
              err_q    <= 1'b1;
              rvalid_q <= 1'b1;
              state_q  <= RRESP;
            end
          end
        end
        WDATA: begin
          if (w_hs) begin
            wdata_q <= axi_req_i.w.data;
            be_q    <= axi_req_i.w.strb;
            we_q    <= 1'b1;
            if (len_q == 8'd0) begin
              en_q    <= w_legal;
              err_q   <= !w_legal;
              state_q <= ACCESS;
            end else if (axi_req_i.w.last) begin
              err_q    <= 1'b1;
              bvalid_q <= 1'b1;
              state_q  <= BRESP;
            end
          end
        end
        ACCESS: begin
          if (we_q) begin
            bvalid_q <= 1'b1;
            state_q  <= BRESP;
          end else begin
            rdata_q  <= err_q ? 64'd0 : data_i;
            rvalid_q <= 1'b1;
            state_q  <= RRESP;
          end
        end
        RRESP: begin
          if (r_hs) begin
            if (cnt_q == 8'd0) begin
              rvalid_q <= 1'b0;
              state_q  <= IDLE;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
        end
        BRESP: begin
          if (b_hs) begin
            bvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = aw_ready;
    axi_resp_o.ar_ready = ar_ready;
    axi_resp_o.w_ready  = w_ready;
    axi_resp_o.b_valid  = bvalid_q;
    axi_resp_o.b.id     = id_q;
    axi_resp_o.b.resp   = err_q ? RESP_SLVERR : RESP_OKAY;
    axi_resp_o.r_valid  = rvalid_q;
    axi_resp_o.r.id     = id_q;
    axi_resp_o.r.data   = rdata_q;
    axi_resp_o.r.resp   = err_q ? RESP_SLVERR : RESP_OKAY;
    axi_resp_o.r.last   = (cnt_q == 8'd0);
  end

  assign address_o = addr_q;
  assign en_o      = en_q;
  assign we_o      = we_q;
  assign be_o      = be_q;
  assign data_o    = wdata_q;

endmodule

// File: tb/tb_clint_axi_bridge.sv
// Scoreboard bench for clint_axi_bridge: directed AXI transactions, monitor pops expectations.
module tb_clint_axi_bridge;
  import clint_bridge_pkg::*;

  localparam int K_EN = 0, K_R = 1, K_B = 2;
  localparam int CH_AW = 0, CH_AR = 1, CH_W = 2;

  typedef struct {
    int          kind;
    logic [63:0] addr;
    logic [63:0] data;
    logic [9:0]  id;
    logic [7:0]  be;
    logic [1:0]  resp;
    logic        last;
    logic        we;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  axi_req_t    req;
  axi_rsp_t    rsp;
  logic [63:0] address_o;
  logic        en_o, we_o;
  logic [7:0]  be_o;
  logic [63:0] data_o, data_i, rd_val;
  int          cyc = 0;
  int          n_chk = 0, n_pass = 0;
  exp_t        sb[$];

  clint_axi_bridge dut (
    .clk_i(clk), .rst_i(rst), .axi_req_i(req), .axi_resp_o(rsp),
    .address_o(address_o), .en_o(en_o), .we_o(we_o), .be_o(be_o),
    .data_o(data_o), .data_i(data_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Garbage outside the strobe cycle exposes sampling in the wrong cycle.
  assign data_i = en_o ? rd_val : 64'hFFFF_0000_FFFF_0000;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic bad(input string name, input string msg);
    n_chk++;
    $display("FAIL %s: %s", name, msg);
  endtask

  function automatic void push_en(input logic [63:0] a, input logic we, input logic [63:0] d,
                                  input logic [7:0] be, input int c);
    exp_t e;
    e = '{kind: K_EN, addr: a, data: d, id: '0, be: be, resp: '0, last: 1'b0, we: we, cyc: c};
    sb.push_back(e);
  endfunction

  function automatic void push_r(input logic [9:0] id, input logic [63:0] d, input logic [1:0] rs,
                                 input logic last, input int c);
    exp_t e;
    e = '{kind: K_R, addr: '0, data: d, id: id, be: '0, resp: rs, last: last, we: 1'b0, cyc: c};
    sb.push_back(e);
  endfunction

  function automatic void push_b(input logic [9:0] id, input logic [1:0] rs, input int c);
    exp_t e;
    e = '{kind: K_B, addr: '0, data: '0, id: id, be: '0, resp: rs, last: 1'b0, we: 1'b0, cyc: c};
    sb.push_back(e);
  endfunction

  // Monitor: pops one expectation per DUT event.
  initial begin : monitor
    exp_t   e;
    logic   hold;
    axi_r_t held;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
        continue;
      end
      if (hold && rsp.r_valid) chk("r_stable", rsp.r, held);
      hold = rsp.r_valid && !req.r_ready;
      held = rsp.r;
      if (en_o) begin
        if (sb.size() == 0 || sb[0].kind != K_EN)
          bad("en_unexpected", $sformatf("got strobe at address %0h, required none", address_o));
        else begin
          e = sb.pop_front();
          chk("en_addr", address_o, e.addr);
          chk("en_we", we_o, e.we);
          chk("en_be", be_o, e.be);
          if (e.we) chk("en_data", data_o, e.data);
          if (e.cyc >= 0) chk("en_cycle", cyc, e.cyc);
        end
      end
      if (rsp.r_valid && req.r_ready) begin
        if (sb.size() == 0 || sb[0].kind != K_R)
          bad("r_unexpected", $sformatf("got R id %0h, required none", rsp.r.id));
        else begin
          e = sb.pop_front();
          chk("r_id", rsp.r.id, e.id);
          chk("r_data", rsp.r.data, e.data);
          chk("r_resp", rsp.r.resp, e.resp);
          chk("r_last", rsp.r.last, e.last);
          if (e.cyc >= 0) chk("r_cycle", cyc, e.cyc);
        end
      end
      if (rsp.b_valid && req.b_ready) begin
        if (sb.size() == 0 || sb[0].kind != K_B)
          bad("b_unexpected", $sformatf("got B id %0h, required none", rsp.b.id));
        else begin
          e = sb.pop_front();
          chk("b_id", rsp.b.id, e.id);
          chk("b_resp", rsp.b.resp, e.resp);
          if (e.cyc >= 0) chk("b_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic wait_hs(input int ch, output int c);
    c = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ch == CH_AW && req.aw_valid && rsp.aw_ready) c = cyc;
      if (ch == CH_AR && req.ar_valid && rsp.ar_ready) c = cyc;
      if (ch == CH_W  && req.w_valid  && rsp.w_ready)  c = cyc;
      if (c >= 0) break;
    end
    if (c < 0) bad("hs_timeout", $sformatf("channel %0d got no handshake, required one", ch));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) begin
      bad("drain_timeout", $sformatf("%0d responses outstanding, required 0", sb.size()));
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic set_aw(input logic [63:0] a, input logic [9:0] id, input logic [7:0] len);
    req.aw.addr = a; req.aw.id = id; req.aw.len = len;
  endtask

  task automatic set_ar(input logic [63:0] a, input logic [9:0] id, input logic [7:0] len);
    req.ar.addr = a; req.ar.id = id; req.ar.len = len;
  endtask

  task automatic set_w(input logic [63:0] d, input logic [7:0] s, input logic last);
    req.w.data = d; req.w.strb = s; req.w.last = last;
  endtask

  task automatic do_read(input logic [63:0] a, input logic [9:0] id, input logic [63:0] v);
    int c;
    rd_val = v;
    set_ar(a, id, 8'd0);
    req.ar_valid = 1'b1;
    wait_hs(CH_AR, c);
    req.ar_valid = 1'b0;
    push_en(a, 1'b0, '0, 8'hFF, c + 1);
    push_r(id, v, RESP_OKAY, 1'b1, c + 2);
  endtask

  initial begin
    int c;
    rst = 1'b1;
    req = '0;
    req.b_ready = 1'b1;
    req.r_ready = 1'b1;
    rd_val = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_aw_ready", rsp.aw_ready, 1'b0);
    chk("rst_ar_ready", rsp.ar_ready, 1'b0);
    chk("rst_w_ready", rsp.w_ready, 1'b0);
    chk("rst_b_valid", rsp.b_valid, 1'b0);
    chk("rst_r_valid", rsp.r_valid, 1'b0);
    chk("rst_en_we", {en_o, we_o}, 2'b00);
    chk("rst_addr", address_o, 64'd0);
    chk("rst_data", data_o, 64'd0);
    chk("rst_be", be_o, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single write
    set_aw(64'h4000, 10'h5, 8'd0);
    set_w(64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b1);
    req.aw_valid = 1'b1;
    req.w_valid  = 1'b1;
    wait_hs(CH_AW, c);
    req.aw_valid = 1'b0;
    wait_hs(CH_W, c);
    req.w_valid = 1'b0;
    push_en(64'h4000, 1'b1, 64'hDEAD_BEEF_0000_0001, 8'hFF, c + 1);
    push_b(10'h5, RESP_OKAY, c + 2);
    drain();

    // Single read
    do_read(64'hBFF8, 10'h3, 64'h1234);
    drain();

    // Both address channels valid: write, read, write, read
    for (int t = 0; t < 2; t++) begin
      set_aw(64'h10 * t, 10'h11 + t, 8'd0);
      set_w(64'hA5A5_0000_0000_0000 + t, 8'h0F << t, 1'b1);
      set_ar(64'h4008 + 64'h8 * t, 10'h22 + t, 8'd0);
      rd_val = 64'h7700 + t;
      req.aw_valid = 1'b1;
      req.ar_valid = 1'b1;
      req.w_valid  = 1'b1;
      wait_hs(CH_AW, c);
      req.aw_valid = 1'b0;
      wait_hs(CH_W, c);
      req.w_valid = 1'b0;
      push_en(64'h10 * t, 1'b1, 64'hA5A5_0000_0000_0000 + t, 8'h0F << t, c + 1);
      push_b(10'h11 + t, RESP_OKAY, c + 2);
      wait_hs(CH_AR, c);
      req.ar_valid = 1'b0;
      push_en(64'h4008 + 64'h8 * t, 1'b0, '0, 8'hFF, c + 1);
      push_r(10'h22 + t, 64'h7700 + t, RESP_OKAY, 1'b1, c + 2);
      drain();
    end

    // Read burst len=3 with r_ready toggling
    set_ar(64'h0, 10'h7, 8'd3);
    req.ar_valid = 1'b1;
    req.r_ready  = 1'b0;
    wait_hs(CH_AR, c);
    req.ar_valid = 1'b0;
    for (int i = 0; i < 4; i++) push_r(10'h7, 64'd0, RESP_SLVERR, i == 3, -1);
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      req.r_ready = i[0];
      @(posedge clk); #1;
    end
    req.r_ready = 1'b1;
    drain();

    // Write burst len=1
    set_aw(64'h10, 10'h2, 8'd1);
    set_w(64'h1111, 8'hFF, 1'b0);
    req.aw_valid = 1'b1;
    req.w_valid  = 1'b1;
    wait_hs(CH_AW, c);
    req.aw_valid = 1'b0;
    wait_hs(CH_W, c);
    set_w(64'h2222, 8'hF0, 1'b1);
    wait_hs(CH_W, c);
    req.w_valid = 1'b0;
    push_b(10'h2, RESP_SLVERR, -1);
    drain();

    // Read burst len=255: 256 beats, last only on the final one
    set_ar(64'h8, 10'h3FF, 8'd255);
    req.ar_valid = 1'b1;
    wait_hs(CH_AR, c);
    req.ar_valid = 1'b0;
    for (int i = 0; i < 256; i++) push_r(10'h3FF, 64'd0, RESP_SLVERR, i == 255, -1);
    drain();

    // Reset while R is stalled
    req.r_ready = 1'b0;
    rd_val = 64'h55;
    set_ar(64'h8, 10'h1, 8'd0);
    req.ar_valid = 1'b1;
    wait_hs(CH_AR, c);
    req.ar_valid = 1'b0;
    push_en(64'h8, 1'b0, '0, 8'hFF, c + 1);
    c = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp.r_valid) begin
        c = 1;
        break;
      end
    end
    if (c == 0) bad("rst_wait_rvalid", "r_valid never rose, required 1");
    chk("rst_sb_before", sb.size(), 0);
    rst = 1'b1;
    #1;
    chk("midrst_r_valid", rsp.r_valid, 1'b0);
    chk("midrst_en", en_o, 1'b0);
    sb.delete();
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    req.r_ready = 1'b1;
    #1;
    chk("postrst_idle_ar_ready", rsp.ar_ready, 1'b1);
    chk("postrst_r_valid", rsp.r_valid, 1'b0);
    @(posedge clk); #1;
    do_read(64'hBFF8, 10'h3A, 64'hCAFE_F00D);
    drain();

    // Unaligned read
    rd_val = 64'h99;
    set_ar(64'h4, 10'h15, 8'd0);
    req.ar_valid = 1'b1;
    wait_hs(CH_AR, c);
    req.ar_valid = 1'b0;
`ifdef CLINT_BRIDGE_ADDR_CHECK_EN
    push_r(10'h15, 64'd0, RESP_SLVERR, 1'b1, c + 2);
`else
    push_en(64'h4, 1'b0, '0, 8'hFF, c + 1);
    push_r(10'h15, 64'h99, RESP_OKAY, 1'b1, c + 2);
`endif
    drain();

    repeat (4) @(posedge clk);
    chk("sb_empty_end", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
